// File: rtl/eng_uc_port_pkg.sv
// Shared types and defaults for the engine-side unit-clause port.
// A literal is {sign, variable index} and orders as an unsigned number.
package eng_uc_port_pkg;

   localparam int LIT_IDX_MAX   = 127;
   localparam int LIT_IDX_W     = $clog2(LIT_IDX_MAX + 1);
   localparam int LIT_W         = LIT_IDX_W + 1;
   localparam int NUM_ENGINE    = 4;
   localparam int UCP_OUT_DEPTH = 8;
   localparam int UCP_IN_DEPTH  = 8;

   typedef struct packed {
      logic                 sign;
      logic [LIT_IDX_W-1:0] idx;
   } lit_t;

   // Unsigned ordering over the whole {sign, index} word.
   function automatic logic lit_lt(input lit_t a, input lit_t b);
      return {a.sign, a.idx} < {b.sign, b.idx};
   endfunction

endpackage

// File: rtl/eng_uc_port_bcast_fifo.sv
// Broadcast FIFO: show-ahead circular buffer with wrap-bit pointers and a
// sticky overflow flag for broadcasts that found no room.
module uc_bcast_fifo
   import eng_uc_port_pkg::*;
#(
   parameter int IN_DEPTH = UCP_IN_DEPTH
) (
   input  logic clk,
   input  logic rst,
   input  logic flush,
   input  logic push,
   input  lit_t din,
   input  logic pop,
   output logic full,
   output logic valid,
   output lit_t dout,
   output logic ovf
);

   localparam int AW = $clog2(IN_DEPTH);

   logic [AW:0] wr_ptr_reg, wr_ptr_next;
   logic [AW:0] rd_ptr_reg, rd_ptr_next;
   logic        ovf_reg, ovf_next;
   lit_t        mem [IN_DEPTH];

   logic empty;
   logic pop_ok;
   logic push_ok;

   assign empty   = (wr_ptr_reg == rd_ptr_reg);
   assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign pop_ok  = pop && !empty;
   // A pop in the same cycle frees the slot the push needs.
   assign push_ok = push && (!full || pop_ok);

   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      ovf_next    = ovf_reg;
      if (flush) begin
         wr_ptr_next = '0;
         rd_ptr_next = '0;
      end else begin
         if (push_ok)
            wr_ptr_next = wr_ptr_reg + (AW+1)'(1);
         if (pop_ok)
            rd_ptr_next = rd_ptr_reg + (AW+1)'(1);
         if (push && !push_ok)
            ovf_next = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         ovf_reg    <= 1'b0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         ovf_reg    <= ovf_next;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && !flush && push_ok)
         mem[wr_ptr_reg[AW-1:0]] <= din;
   end

   assign valid = !empty;
   assign dout  = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];
   assign ovf   = ovf_reg;

endmodule

// File: rtl/eng_uc_port.sv
// Engine-side unit-clause port: implied-literal buffer with min search plus
// the broadcast FIFO. Define UCP_DEDUP_EN to absorb duplicate implied pushes.
module eng_uc_port
   import eng_uc_port_pkg::*;
#(
   parameter int OUT_DEPTH = UCP_OUT_DEPTH,
   parameter int IN_DEPTH  = UCP_IN_DEPTH
) (
   input  logic clk,
   input  logic rst,
   input  logic eng_push,
   input  lit_t eng_lit,
   output logic eng_ready,
   output lit_t eng2uca_min,
   output logic eng2uca_valid,
   output logic eng2uca_empty,
   input  logic uca2eng_pop,
   input  logic uca2eng_push,
   input  lit_t uca2eng_lit,
   output logic eng2uca_full,
   output logic eng_in_valid,
   output lit_t eng_in_lit,
   input  logic eng_in_pop,
   input  logic eng_flush,
   output logic in_ovf
);

   localparam int OW = $clog2(OUT_DEPTH);

   logic [OUT_DEPTH-1:0] valid_reg, valid_next;
   lit_t                 lit_reg [OUT_DEPTH];

   logic [OUT_DEPTH-1:0] set_slot, clr_slot;
   logic [OW-1:0]        min_idx, free_idx;
   lit_t                 min_lit;
   logic                 buf_full, buf_empty;
   logic                 dup_absorb;
   logic                 push_do, pop_do;

   assign buf_full  = &valid_reg;
   assign buf_empty = ~|valid_reg;

   // Strict less-than keeps the earliest slot on ties.
   always_comb begin
      logic any;
      any     = 1'b0;
      min_lit = '0;
      min_idx = '0;
      for (int i = 0; i < OUT_DEPTH; i++) begin
         if (valid_reg[i] && (!any || lit_lt(lit_reg[i], min_lit))) begin
            any     = 1'b1;
            min_lit = lit_reg[i];
            min_idx = OW'(i);
         end
      end
   end

   always_comb begin
      free_idx = '0;
      for (int i = OUT_DEPTH - 1; i >= 0; i--) begin
         if (!valid_reg[i])
            free_idx = OW'(i);
      end
   end

`ifdef UCP_DEDUP_EN
   logic [OUT_DEPTH-1:0] dup_hit;
   for (genvar gi = 0; gi < OUT_DEPTH; gi++) begin : g_dup
      assign dup_hit[gi] = valid_reg[gi] && (lit_reg[gi] == eng_lit);
   end
   assign dup_absorb = |dup_hit;
`else
   assign dup_absorb = 1'b0;
`endif

   assign push_do = eng_push && !buf_full && !dup_absorb;
   assign pop_do  = uca2eng_pop && !buf_empty;

   // The push target is free and the pop target is valid, so they never collide.
   for (genvar gi = 0; gi < OUT_DEPTH; gi++) begin : g_slot
      assign set_slot[gi]   = push_do && (free_idx == OW'(gi));
      assign clr_slot[gi]   = pop_do && (min_idx == OW'(gi));
      assign valid_next[gi] = eng_flush    ? 1'b0 :
                              set_slot[gi] ? 1'b1 :
                              clr_slot[gi] ? 1'b0 : valid_reg[gi];

      always_ff @(posedge clk) begin
         if (!rst && !eng_flush && set_slot[gi])
            lit_reg[gi] <= eng_lit;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         valid_reg <= '0;
      else
         valid_reg <= valid_next;
   end

   assign eng_ready     = !buf_full;
   assign eng2uca_min   = min_lit;
   assign eng2uca_valid = !buf_empty;
   assign eng2uca_empty = buf_empty;

   uc_bcast_fifo #(
      .IN_DEPTH (IN_DEPTH)
   ) u_bcast_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (eng_flush),
      .push  (uca2eng_push),
      .din   (uca2eng_lit),
      .pop   (eng_in_pop),
      .full  (eng2uca_full),
      .valid (eng_in_valid),
      .dout  (eng_in_lit),
      .ovf   (in_ovf)
   );

endmodule

// File: tb/tb_eng_uc_port.sv
// Bench for eng_uc_port: directed scenarios then random traffic, all checked
// against a multiset/queue reference model of the two buffers.
module tb_eng_uc_port;
   import eng_uc_port_pkg::*;

   localparam int OUT_D = UCP_OUT_DEPTH;
   localparam int IN_D  = UCP_IN_DEPTH;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic eng_push = 1'b0;
   lit_t eng_lit = '0;
   logic eng_ready;
   lit_t eng2uca_min;
   logic eng2uca_valid;
   logic eng2uca_empty;
   logic uca2eng_pop = 1'b0;
   logic uca2eng_push = 1'b0;
   lit_t uca2eng_lit = '0;
   logic eng2uca_full;
   logic eng_in_valid;
   lit_t eng_in_lit;
   logic eng_in_pop = 1'b0;
   logic eng_flush = 1'b0;
   logic in_ovf;

   eng_uc_port #(.OUT_DEPTH(OUT_D), .IN_DEPTH(IN_D)) dut (
      .clk           (clk),
      .rst           (rst),
      .eng_push      (eng_push),
      .eng_lit       (eng_lit),
      .eng_ready     (eng_ready),
      .eng2uca_min   (eng2uca_min),
      .eng2uca_valid (eng2uca_valid),
      .eng2uca_empty (eng2uca_empty),
      .uca2eng_pop   (uca2eng_pop),
      .uca2eng_push  (uca2eng_push),
      .uca2eng_lit   (uca2eng_lit),
      .eng2uca_full  (eng2uca_full),
      .eng_in_valid  (eng_in_valid),
      .eng_in_lit    (eng_in_lit),
      .eng_in_pop    (eng_in_pop),
      .eng_flush     (eng_flush),
      .in_ovf        (in_ovf)
   );

   always #5 clk = ~clk;

`ifdef UCP_DEDUP_EN
   localparam bit DEDUP = 1'b1;
`else
   localparam bit DEDUP = 1'b0;
`endif

   int total = 0;
   int bad   = 0;
   int txn   = 0;

   // Reference state: implied buffer as a multiset, broadcast FIFO as a queue.
   logic [7:0] imp_m[$];
   logic [7:0] fifo_m[$];
   bit         ovf_m = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (txn %0d)", tag, got, exp, txn);
      end
   endtask

   function automatic logic [7:0] model_min();
      logic [7:0] m;
      m = 8'hFF;
      foreach (imp_m[i])
         if (imp_m[i] < m) m = imp_m[i];
      return (imp_m.size() == 0) ? 8'h00 : m;
   endfunction

   function automatic bit model_has(input logic [7:0] v);
      foreach (imp_m[i])
         if (imp_m[i] == v) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_edge(input bit r, input bit ep, input logic [7:0] el, input bit up,
                             input bit bp, input logic [7:0] bl, input bit ip, input bit fl);
      logic [7:0] m;
      bit pop_ok, push_ok;
      if (r) begin
         imp_m.delete();
         fifo_m.delete();
         ovf_m = 1'b0;
      end else if (fl) begin
         imp_m.delete();
         fifo_m.delete();
      end else begin
         m = model_min();
         pop_ok = up && (imp_m.size() != 0);
         if (ep && imp_m.size() < OUT_D && !(DEDUP && model_has(el)))
            imp_m.push_back(el);
         if (pop_ok) begin
            foreach (imp_m[i])
               if (imp_m[i] == m) begin
                  imp_m.delete(i);
                  break;
               end
         end
         pop_ok  = ip && (fifo_m.size() != 0);
         push_ok = bp && ((fifo_m.size() < IN_D) || pop_ok);
         if (bp && !push_ok) ovf_m = 1'b1;
         if (pop_ok) void'(fifo_m.pop_front());
         if (push_ok) fifo_m.push_back(bl);
      end
   endtask

   task automatic check_all();
      chk("eng_ready", eng_ready, imp_m.size() < OUT_D);
      chk("uca_valid", eng2uca_valid, imp_m.size() != 0);
      chk("uca_empty", eng2uca_empty, imp_m.size() == 0);
      chk("uca_min", eng2uca_min, model_min());
      chk("uca_full", eng2uca_full, fifo_m.size() == IN_D);
      chk("in_valid", eng_in_valid, fifo_m.size() != 0);
      chk("in_lit", eng_in_lit, (fifo_m.size() != 0) ? fifo_m[0] : 8'h00);
      chk("in_ovf", in_ovf, ovf_m);
   endtask

   task automatic step(input bit r, input bit ep, input logic [7:0] el, input bit up,
                       input bit bp, input logic [7:0] bl, input bit ip, input bit fl);
      @(negedge clk);
      rst = r; eng_push = ep; eng_lit = lit_t'(el); uca2eng_pop = up;
      uca2eng_push = bp; uca2eng_lit = lit_t'(bl); eng_in_pop = ip; eng_flush = fl;
      @(posedge clk);
      model_edge(r, ep, el, up, bp, bl, ip, fl);
      #1;
      txn++;
      $display("txn %0d rst=%0b push=%0b/%02h pop=%0b bpush=%0b/%02h bpop=%0b flush=%0b -> min=%02h imp=%0d fifo=%0d ovf=%0b",
               txn, r, ep, el, up, bp, bl, ip, fl, eng2uca_min, imp_m.size(), fifo_m.size(), in_ovf);
      check_all();
   endtask

   task automatic idle();
      step(0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
   endtask

   initial begin
      // Reset state
      step(1, 0, 8'h00, 0, 0, 8'h00, 0, 0);
      chk("rst_ready", eng_ready, 1);
      chk("rst_empty", eng2uca_empty, 1);
      chk("rst_min", eng2uca_min, 0);

      // Min ordering across pops
      step(0, 1, 8'h14, 0, 0, 8'h00, 0, 0);
      step(0, 1, 8'h06, 0, 0, 8'h00, 0, 0);
      step(0, 1, 8'h22, 0, 0, 8'h00, 0, 0);
      chk("min_first", eng2uca_min, 8'h06);
      step(0, 0, 8'h00, 1, 0, 8'h00, 0, 0);
      chk("min_second", eng2uca_min, 8'h14);
      step(0, 0, 8'h00, 1, 0, 8'h00, 0, 0);
      chk("min_third", eng2uca_min, 8'h22);
      step(0, 0, 8'h00, 1, 0, 8'h00, 0, 0);
      chk("empty_after_pops", eng2uca_empty, 1);
      step(0, 0, 8'h00, 1, 0, 8'h00, 0, 0);

      // Fill, ignored push while full, then simultaneous pop+push
      for (int i = 0; i < OUT_D; i++)
         step(0, 1, 8'h50 + 8'(i), 0, 0, 8'h00, 0, 0);
      chk("full_ready", eng_ready, 0);
      step(0, 1, 8'h01, 0, 0, 8'h00, 0, 0);
      chk("full_push_ignored", eng2uca_min, 8'h50);
      step(0, 0, 8'h00, 1, 0, 8'h00, 0, 0);
      step(0, 1, 8'h01, 1, 0, 8'h00, 0, 0);
      chk("pop_push_min", eng2uca_min, 8'h01);

      // Broadcast FIFO fill, overflow, pop+push while full
      for (int i = 0; i < IN_D; i++)
         step(0, 0, 8'h00, 0, 1, 8'h30 + 8'(i), 0, 0);
      chk("bfull", eng2uca_full, 1);
      chk("bfull_ovf0", in_ovf, 0);
      step(0, 0, 8'h00, 0, 1, 8'h38, 0, 0);
      chk("bovf", in_ovf, 1);
      step(0, 0, 8'h00, 0, 1, 8'h39, 1, 0);
      chk("bpp_full", eng2uca_full, 1);
      chk("bpp_head", eng_in_lit, 8'h31);

      // Flush keeps overflow, then 1-cycle write-to-read and empty pop
      step(0, 0, 8'h00, 0, 0, 8'h00, 0, 1);
      step(0, 0, 8'h00, 0, 1, 8'h40, 0, 0);
      chk("lat_valid", eng_in_valid, 1);
      chk("lat_lit", eng_in_lit, 8'h40);
      step(0, 0, 8'h00, 0, 0, 8'h00, 1, 0);
      step(0, 0, 8'h00, 0, 0, 8'h00, 1, 0);
      step(0, 0, 8'h00, 0, 1, 8'h41, 0, 0);
      chk("empty_pop_noop", eng_in_lit, 8'h41);

      // Flush with simultaneous pushes from both sides
      step(1, 0, 8'h00, 0, 0, 8'h00, 0, 0);
      step(0, 0, 8'h00, 0, 1, 8'h60, 0, 0);
      step(0, 0, 8'h00, 0, 1, 8'h61, 0, 0);
      for (int i = 0; i < IN_D; i++)
         step(0, 0, 8'h00, 0, 1, 8'h62, 0, 0);
      step(0, 0, 8'h00, 0, 0, 8'h00, 0, 1);
      for (int i = 0; i < 3; i++)
         step(0, 1, 8'h20 + 8'(i), 0, 0, 8'h00, 0, 0);
      for (int i = 0; i < 5; i++)
         step(0, 0, 8'h00, 0, 1, 8'h70 + 8'(i), 0, 0);
      step(0, 1, 8'h05, 1, 1, 8'h7F, 1, 1);
      chk("flush_imp_empty", eng2uca_empty, 1);
      chk("flush_fifo_empty", eng_in_valid, 0);
      chk("flush_ovf_kept", in_ovf, 1);

      // Duplicate handling
      step(1, 0, 8'h00, 0, 0, 8'h00, 0, 0);
      step(0, 1, 8'h10, 0, 0, 8'h00, 0, 0);
      step(0, 1, 8'h10, 0, 0, 8'h00, 0, 0);
      step(0, 0, 8'h00, 1, 0, 8'h00, 0, 0);
      chk("dup_one_pop", eng2uca_empty, DEDUP ? 1 : 0);
      step(0, 0, 8'h00, 1, 0, 8'h00, 0, 0);
      chk("dup_two_pops", eng2uca_empty, 1);

      // Random traffic
      for (int n = 0; n < 1500; n++) begin
         logic [7:0] el, bl;
         el = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
         bl = 8'($urandom);
         step(($urandom_range(0, 199) == 0),
              ($urandom_range(0, 99) < 55), el,
              ($urandom_range(0, 99) < 40),
              ($urandom_range(0, 99) < 50), bl,
              ($urandom_range(0, 99) < 45),
              ($urandom_range(0, 49) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/eng_uc_port.md
Name: eng_uc_port

Overview:
- Engine-side endpoint of the unit-clause arbitration protocol. One instance per engine.
- Implied-UC buffer (UCQ_IN): collects literals the engine implies and presents the minimum literal to the arbiter. The arbiter pops it.
- Broadcast FIFO (UCQ_OUT): receives literals the arbiter broadcasts to all engines. The engine drains it. The port reports full back to the arbiter.

Parameters:
- OUT_DEPTH, 8: implied-UC buffer slots; power of two, 2..16.
- IN_DEPTH, 8: broadcast FIFO entries; power of two, 2..64.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- eng_push  in  1  engine offers an implied literal
- eng_lit  in  lit_t  implied literal
- eng_ready  out  1  implied buffer can accept (not full)
- eng2uca_min  out  lit_t  smallest buffered implied literal; 0 when empty
- eng2uca_valid  out  1  implied buffer non-empty
- eng2uca_empty  out  1  implied buffer empty (equals ~eng2uca_valid)
- uca2eng_pop  in  1  arbiter consumes eng2uca_min this cycle
- uca2eng_push  in  1  arbiter broadcast strobe
- uca2eng_lit  in  lit_t  broadcast literal
- eng2uca_full  out  1  broadcast FIFO full
- eng_in_valid  out  1  broadcast FIFO non-empty
- eng_in_lit  out  lit_t  FIFO head (show-ahead); 0 when empty
- eng_in_pop  in  1  engine consumes head
- eng_flush  in  1  backtrack: discard both buffers
- in_ovf  out  1  sticky; a broadcast was dropped

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - All slots invalid, pointers 0, in_ovf=0.
  - Outputs after reset: eng_ready=1, eng2uca_valid=0, eng2uca_empty=1, eng2uca_min=0, eng2uca_full=0, eng_in_valid=0, eng_in_lit=0.
  - rst overrides every other input, including mid-operation.
- Implied buffer:
  - Storage is OUT_DEPTH slots, each holding a valid bit and a lit_t.
  - eng_push && eng_ready writes eng_lit into the lowest-index free slot at the posedge. The literal is visible on eng2uca_min the next cycle.
  - eng_push while full is ignored; no state change.
  - eng2uca_min is the unsigned minimum over valid slots, combinational from registered state. Ties resolve to the lowest slot index.
  - uca2eng_pop clears the slot that supplies eng2uca_min at the posedge.
  - Pop when empty is ignored.
  - Push and pop in the same cycle are both performed; the pop applies to the pre-edge minimum.
  - eng_ready = ~full; there is no same-cycle bypass.
- Broadcast FIFO:
  - Circular buffer with wr_ptr and rd_ptr, each carrying an extra wrap bit.
  - full: pointers differ only in the wrap bit. empty: pointers are equal.
  - uca2eng_push is accepted if the FIFO is not full, or if eng_in_pop && !empty in the same cycle.
  - Otherwise the push is dropped and in_ovf is set.
  - eng_in_pop when empty is ignored.
  - Simultaneous push and pop on a non-empty FIFO leaves occupancy unchanged.
  - Write-to-read latency is 1 cycle: a push at edge N gives eng_in_valid=1 after edge N.
  - eng2uca_full is registered state, not a bypass.
- Flush:
  - eng_flush clears all implied slots and sets both FIFO pointers to 0 at the posedge.
  - in_ovf is not cleared by flush; only rst clears it.
  - Flush wins over push and pop in the same cycle.
- Pointer arithmetic wraps modulo 2*IN_DEPTH.

Optional Feature:
- Macro: UCP_DEDUP_EN.
- Defined: eng_push whose eng_lit equals a literal already valid in the implied buffer completes with no new slot allocated. eng_ready is unaffected. A duplicate push while full is also absorbed silently.
- Undefined: duplicates occupy separate slots and are popped one per arbiter pop.

Decomposition:
- Shared package holds:
  - lit_t: LIT_W-bit value, {sign, index}.
  - LIT_IDX_MAX and NUM_ENGINE.
  - Default depths UCP_OUT_DEPTH and UCP_IN_DEPTH.
- One sub-module: uc_bcast_fifo (the broadcast FIFO, parameterised by IN_DEPTH).
- The implied buffer with its min-tree stays in eng_uc_port.

Test Plan:
- Reset then push 0x14, 0x06, 0x22 -> eng2uca_min 0x06, then 0x14, then 0x22 on successive pops; eng2uca_empty=1 after the third pop.
- Fill the implied buffer with 8 literals -> eng_ready=0. A 9th push changes nothing. Pop plus push 0x01 in the same cycle -> next eng2uca_min=0x01.
- Broadcast 8 literals 0x30..0x37 with no engine pop -> eng2uca_full=1. A 9th push sets in_ovf=1. Pop-and-push while full -> occupancy stays 8, no overflow.
- Broadcast 0x40 at edge N -> eng_in_valid=1 and eng_in_lit=0x40 after N. eng_in_pop on an empty FIFO -> no pointer change.
- Buffers hold 3 implied and 5 broadcast entries, then eng_flush with a simultaneous push -> both empty next cycle; in_ovf holds its prior value.
- With UCP_DEDUP_EN, push 0x10 twice then pop once -> empty. Without the macro -> two pops are required.
